approx_rc_pipe: RTL and testbench
=================================

Name: approx_rc_pipe

Overview:
- Parametrised, pipelined successor of the fixed 8-bit ripple-carry adder with 3 approximate low cells.
- The number of approximate LSB cells, k, is chosen per transaction at run time.
- An exact-sum shadow path runs through the same pipeline. Built-in error statistics (mismatch count, accumulated absolute error) support MAE characterisation on silicon and in simulation.
- Sits between an operand source and a sink, using valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand width in bits (≥2).
- STAGE_W, 4, bits per pipeline stage; NUM_STAGES = ceil(WIDTH/STAGE_W).
- K_W, $clog2(WIDTH+1), width of the k input.
- CNT_W, 16, mismatch counter width.
- ACC_W, 32, absolute-error accumulator width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block accepts a transaction this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_k  in  K_W  number of approximate LSB cells; values > WIDTH clamp to WIDTH.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts the result.
- out_sum  out  WIDTH+1  approximate sum.
- out_exact  out  WIDTH+1  exact sum a+b.
- out_err  out  1  out_sum != out_exact.
- stats_clear  in  1  synchronous clear of the statistics.
- err_count  out  CNT_W  saturating count of mismatched results delivered.
- abs_err_acc  out  ACC_W  saturating sum of |out_exact - out_sum| over results delivered.

Behaviour:
- Reset:
  - All stage valid bits, out_valid, out_sum, out_exact, out_err, err_count and abs_err_acc are 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - Reset mid-operation discards every in-flight transaction; no output handshake follows.
- Approximate cell, bit i < k:
  - S = (X|Y) & ~Cin and Cout = 0.
  - Cell 0 has Cin = 0, so every approximate bit reduces to S = X|Y with carry 0.
- Exact cells, bits i ≥ k: full adder. Carry into bit k is 0.
- out_sum[WIDTH] is the carry-out of bit WIDTH-1. When k = WIDTH, out_sum[WIDTH] = 0.
- k = 0 makes out_sum identical to out_exact.
- Exact path: conventional ripple carry with carry-in 0, computed slice by slice in the same pipeline stages.
- Pipeline:
  - Stage s computes bits [s*STAGE_W, min((s+1)*STAGE_W, WIDTH)-1] of both paths.
  - Registered carries (approximate and exact) pass between stages.
  - Unprocessed operand bits and k are skewed forward with the transaction.
  - The last stage's registers drive out_sum, out_exact and out_err directly.
- Latency: NUM_STAGES cycles from the input handshake to out_valid, with no stall.
- Throughput: 1 transaction/cycle.
- Handshake:
  - Global stall: advance = !(out_valid && !out_ready). in_ready = advance.
  - All stages shift only when advance = 1. A bubble (in_valid = 0) enters as valid = 0.
  - While out_valid = 1 and out_ready = 0, the out_* signals hold stable.
  - in_valid may drop without handshake; in_a/in_b/in_k are sampled only on in_valid && in_ready.
- Statistics, updated on the output handshake (out_valid && out_ready):
  - err_count += out_err.
  - abs_err_acc += |out_exact - out_sum|, computed over WIDTH+1 bits and zero-extended.
  - Both saturate at all-ones; no wrap.
  - stats_clear with no handshake: both counters become 0.
  - stats_clear together with a handshake: counters load that handshake's contribution (clear, then add).
- Simultaneous input and output handshakes in the same cycle are legal and required for full throughput.

Decomposition:
- Package approx_adder_pkg: the approximate-cell function, the exact full-adder function, and the abs-diff function.
- Sub-module approx_rc_slice (combinational):
  - Inputs: STAGE_W-bit operand slice, base bit index, k, approximate Cin, exact Cin.
  - Outputs: both sum slices and both carry-outs.
  - Instantiated NUM_STAGES times, with the last slice narrowed when WIDTH % STAGE_W != 0.

Test Plan:
- WIDTH=8, k=3, a=0x07, b=0x01, out_ready=1 → after 2 cycles: out_sum=0x007, out_exact=0x008, out_err=1, err_count=1, abs_err_acc=1.
- k=3, a=0xFF, b=0x01 → out_sum=0x0FF, out_exact=0x100, abs_err_acc increases by 1. k=0 with the same operands → out_sum=0x100, out_err=0.
- k=8 (and k=15, which clamps to 8), a=0xFF, b=0xFF → out_sum=0x0FF, out_exact=0x1FE, error 255. a=0x0F, b=0xF0 → out_sum=0x0FF, out_err=0.
- Back-to-back stream of 10 transactions while out_ready toggles 1,0,0,1 → in-order delivery, no loss or duplication, outputs stable during stall, in_ready=0 exactly while stalled.
- Preload err_count to near max (CNT_W=4, 16 mismatches) → saturates at 0xF. stats_clear on the same cycle as a mismatching handshake → err_count=1.
- Reset asserted with 2 transactions in flight → no out_valid afterwards, counters = 0, next transaction has latency NUM_STAGES.

Source files
------------

// File: rtl/approx_adder_pkg.sv
// Shared cell functions for the pipelined approximate ripple-carry adder.
package approx_adder_pkg;

    // Approximate cell: OR of the operands, gated by carry-in; never generates a carry.
    function automatic logic [1:0] approx_cell(input logic x, input logic y, input logic cin);
        return {1'b0, (x | y) & ~cin};
    endfunction

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
        return {(x & y) | (cin & (x ^ y)), x ^ y ^ cin};
    endfunction

    function automatic logic [63:0] abs_diff(input logic [63:0] x, input logic [63:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/approx_rc_slice.sv
// One pipeline slice: computes SW bits of the approximate and exact sums.
module approx_rc_slice
    import approx_adder_pkg::*;
#(
    parameter int SW  = 4,
    parameter int K_W = 4
) (
    input  logic [SW-1:0]  a,
    input  logic [SW-1:0]  b,
    input  logic [K_W-1:0] base,
    input  logic [K_W-1:0] k,
    input  logic           cin_a,
    input  logic           cin_e,
    output logic [SW-1:0]  sum_a,
    output logic [SW-1:0]  sum_e,
    output logic           cout_a,
    output logic           cout_e
);

    // Bits whose absolute index is below k use the approximate cell.
    always_comb begin : p_chain
        logic ca;
        logic ce;
        sum_a = '0;
        sum_e = '0;
        ca    = cin_a;
        ce    = cin_e;
        for (int j = 0; j < SW; j++) begin
            if ((int'(base) + j) < int'(k))
                {ca, sum_a[j]} = approx_cell(a[j], b[j], ca);
            else
                {ca, sum_a[j]} = full_add(a[j], b[j], ca);
            {ce, sum_e[j]} = full_add(a[j], b[j], ce);
        end
        cout_a = ca;
        cout_e = ce;
    end

endmodule

// File: rtl/approx_rc_pipe.sv
// Pipelined approximate ripple-carry adder with run-time k, exact shadow path
// and saturating error statistics.
module approx_rc_pipe
    import approx_adder_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int STAGE_W = 4,
    parameter int K_W     = $clog2(WIDTH + 1),
    parameter int CNT_W   = 16,
    parameter int ACC_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [K_W-1:0]   in_k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic [WIDTH:0]   out_exact,
    output logic             out_err,
    input  logic             stats_clear,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] abs_err_acc
);

    localparam int NS    = (WIDTH + STAGE_W - 1) / STAGE_W;
    localparam int SUM_W = WIDTH + 1;
    localparam int CNT1  = CNT_W + 1;
    localparam int ACC1  = ACC_W + 1;

    logic           advance;
    logic [K_W-1:0] k_clamp;

    logic             v_r  [NS];
    logic             ca_r [NS];
    logic             ce_r [NS];
    logic [K_W-1:0]   k_r  [NS];
    logic [WIDTH-1:0] a_r  [NS];
    logic [WIDTH-1:0] b_r  [NS];
    logic [WIDTH-1:0] sa_r [NS];
    logic [WIDTH-1:0] se_r [NS];
    logic             err_r;

    logic             v_src  [NS];
    logic             ca_src [NS];
    logic             ce_src [NS];
    logic [K_W-1:0]   k_src  [NS];
    logic [WIDTH-1:0] a_src  [NS];
    logic [WIDTH-1:0] b_src  [NS];
    logic [WIDTH-1:0] sa_src [NS];
    logic [WIDTH-1:0] se_src [NS];

    logic             ca_nx [NS];
    logic             ce_nx [NS];
    logic [WIDTH-1:0] sa_nx [NS];
    logic [WIDTH-1:0] se_nx [NS];

    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;
    assign k_clamp  = (in_k > K_W'(WIDTH)) ? K_W'(WIDTH) : in_k;

    for (genvar s = 0; s < NS; s++) begin : g_stage
        localparam int LO = s * STAGE_W;
        localparam int HI = ((s + 1) * STAGE_W > WIDTH) ? WIDTH : (s + 1) * STAGE_W;
        localparam int SW = HI - LO;
        localparam logic [WIDTH-1:0] MASK = ({WIDTH{1'b1}} >> (WIDTH - SW)) << LO;

        logic [SW-1:0] sa_sl;
        logic [SW-1:0] se_sl;

        if (s == 0) begin : g_first
            assign v_src[s]  = in_valid;
            assign ca_src[s] = 1'b0;
            assign ce_src[s] = 1'b0;
            assign k_src[s]  = k_clamp;
            assign a_src[s]  = in_a;
            assign b_src[s]  = in_b;
            assign sa_src[s] = '0;
            assign se_src[s] = '0;
        end else begin : g_next
            assign v_src[s]  = v_r[s-1];
            assign ca_src[s] = ca_r[s-1];
            assign ce_src[s] = ce_r[s-1];
            assign k_src[s]  = k_r[s-1];
            assign a_src[s]  = a_r[s-1];
            assign b_src[s]  = b_r[s-1];
            assign sa_src[s] = sa_r[s-1];
            assign se_src[s] = se_r[s-1];
        end

        approx_rc_slice #(
            .SW  (SW),
            .K_W (K_W)
        ) u_slice (
            .a      (a_src[s][HI-1:LO]),
            .b      (b_src[s][HI-1:LO]),
            .base   (K_W'(LO)),
            .k      (k_src[s]),
            .cin_a  (ca_src[s]),
            .cin_e  (ce_src[s]),
            .sum_a  (sa_sl),
            .sum_e  (se_sl),
            .cout_a (ca_nx[s]),
            .cout_e (ce_nx[s])
        );

        // Merge this slice's bits into the partial sums travelling with the transaction.
        assign sa_nx[s] = (sa_src[s] & ~MASK) | (WIDTH'(sa_sl) << LO);
        assign se_nx[s] = (se_src[s] & ~MASK) | (WIDTH'(se_sl) << LO);
    end

    // Data registers load only with a valid transaction so bubbles leave outputs untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NS; s++) begin
                v_r[s]  <= 1'b0;
                ca_r[s] <= 1'b0;
                ce_r[s] <= 1'b0;
                k_r[s]  <= '0;
                a_r[s]  <= '0;
                b_r[s]  <= '0;
                sa_r[s] <= '0;
                se_r[s] <= '0;
            end
            err_r <= 1'b0;
        end else if (advance) begin
            for (int s = 0; s < NS; s++) begin
                v_r[s] <= v_src[s];
                if (v_src[s]) begin
                    ca_r[s] <= ca_nx[s];
                    ce_r[s] <= ce_nx[s];
                    k_r[s]  <= k_src[s];
                    a_r[s]  <= a_src[s];
                    b_r[s]  <= b_src[s];
                    sa_r[s] <= sa_nx[s];
                    se_r[s] <= se_nx[s];
                end
            end
            if (v_src[NS-1])
                err_r <= {ca_nx[NS-1], sa_nx[NS-1]} != {ce_nx[NS-1], se_nx[NS-1]};
        end
    end

    assign out_valid = v_r[NS-1];
    assign out_sum   = {ca_r[NS-1], sa_r[NS-1]};
    assign out_exact = {ce_r[NS-1], se_r[NS-1]};
    assign out_err   = err_r;

    logic unused_tail;
    assign unused_tail = ^{a_r[NS-1], b_r[NS-1], k_r[NS-1]};

    logic             hs;
    logic [SUM_W-1:0] diff;
    logic [SUM_W-1:0] diff_hs;
    logic [CNT_W-1:0] cnt_base;
    logic [ACC_W-1:0] acc_base;
    logic [CNT_W:0]   cnt_sum;
    logic [ACC_W:0]   acc_sum;
    logic [CNT_W-1:0] cnt_next;
    logic [ACC_W-1:0] acc_next;

    assign hs       = out_valid && out_ready;
    assign diff     = SUM_W'(abs_diff(64'(out_exact), 64'(out_sum)));
    assign diff_hs  = hs ? diff : '0;
    assign cnt_base = stats_clear ? '0 : err_count;
    assign acc_base = stats_clear ? '0 : abs_err_acc;
    assign cnt_sum  = {1'b0, cnt_base} + CNT1'(hs && out_err);
    assign acc_sum  = {1'b0, acc_base} + ACC1'(diff_hs);
    assign cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    assign acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];

    // Clear-then-add: a clear coinciding with a handshake keeps that handshake's contribution.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count   <= '0;
            abs_err_acc <= '0;
        end else if (stats_clear || hs) begin
            err_count   <= cnt_next;
            abs_err_acc <= acc_next;
        end
    end

endmodule

// File: tb/tb_approx_rc_pipe.sv
// Self-checking bench for approx_rc_pipe: arithmetic reference model plus directed vectors.
module tb_approx_rc_pipe;

    localparam int WIDTH = 8;
    localparam int STAGE_W = 4;
    localparam int K_W = 4;
    localparam int CNT_W = 4;
    localparam int ACC_W = 12;
    localparam int NUM_STAGES = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [K_W-1:0]   in_k;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic [WIDTH:0]   out_exact;
    logic             out_err;
    logic             stats_clear;
    logic [CNT_W-1:0] err_count;
    logic [ACC_W-1:0] abs_err_acc;

    approx_rc_pipe #(
        .WIDTH   (WIDTH),
        .STAGE_W (STAGE_W),
        .K_W     (K_W),
        .CNT_W   (CNT_W),
        .ACC_W   (ACC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_k        (in_k),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_exact   (out_exact),
        .out_err     (out_err),
        .stats_clear (stats_clear),
        .err_count   (err_count),
        .abs_err_acc (abs_err_acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH:0] sum;
        logic [WIDTH:0] exact;
        logic           err;
        int             diff;
    } exp_t;

    exp_t expq[$];
    int nCompared = 0;
    int nMismatched = 0;
    int modelCnt = 0;
    int modelAcc = 0;
    logic prevStall = 1'b0;
    logic [WIDTH:0] prevSum, prevExact;
    logic prevErr;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Low k bits are plain OR; the bits above k are an ordinary add of the shifted operands.
    function automatic exp_t modelResult(input int a, input int b, input int k);
        exp_t r;
        int kc, approx, exact;
        kc = (k > WIDTH) ? WIDTH : k;
        approx = ((a | b) & ((1 << kc) - 1)) + (((a >> kc) + (b >> kc)) << kc);
        exact = a + b;
        r.sum = approx[WIDTH:0];
        r.exact = exact[WIDTH:0];
        r.err = (approx != exact);
        r.diff = (exact > approx) ? exact - approx : approx - exact;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            modelCnt = 0;
            modelAcc = 0;
            prevStall = 1'b0;
        end else begin
            checkOutput("err_count", err_count, modelCnt);
            checkOutput("abs_err_acc", abs_err_acc, modelAcc);
            checkOutput("in_ready", in_ready, !(out_valid && !out_ready));
            if (prevStall) begin
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_sum", out_sum, prevSum);
                checkOutput("stall_exact", out_exact, prevExact);
                checkOutput("stall_err", out_err, prevErr);
            end
            if (out_valid) begin
                if (expq.size() == 0) begin
                    checkOutput("unexpected_out", out_valid, 0);
                end else begin
                    checkOutput("out_sum", out_sum, expq[0].sum);
                    checkOutput("out_exact", out_exact, expq[0].exact);
                    checkOutput("out_err", out_err, expq[0].err);
                end
            end
            if (stats_clear) begin
                modelCnt = 0;
                modelAcc = 0;
            end
            if (out_valid && out_ready && expq.size() > 0) begin
                if (expq[0].err) modelCnt = (modelCnt + 1 > CNT_MAX) ? CNT_MAX : modelCnt + 1;
                modelAcc = (modelAcc + expq[0].diff > ACC_MAX) ? ACC_MAX : modelAcc + expq[0].diff;
                void'(expq.pop_front());
            end
            if (in_valid && in_ready)
                expq.push_back(modelResult(int'(in_a), int'(in_b), int'(in_k)));
            prevStall = out_valid && !out_ready;
            prevSum = out_sum;
            prevExact = out_exact;
            prevErr = out_err;
        end
    end

    task automatic syncDrive();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [K_W-1:0] k);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_k = k;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) checkOutput("input_handshake_timeout", 0, 1);
    endtask

    task automatic waitOutput(output int lat);
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) return;
        end
        checkOutput("output_timeout", 0, 1);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (expq.size() == 0 && !out_valid) return;
        end
        checkOutput("drain_timeout", expq.size(), 0);
    endtask

    task automatic expectResult(input string tag, input logic [WIDTH:0] s, input logic [WIDTH:0] e, input logic err);
        int lat;
        waitOutput(lat);
        checkOutput({tag, "_latency"}, lat, NUM_STAGES);
        checkOutput({tag, "_sum"}, out_sum, s);
        checkOutput({tag, "_exact"}, out_exact, e);
        checkOutput({tag, "_err"}, out_err, err);
    endtask

    task automatic expectStats(input string tag, input int cnt, input int acc);
        @(negedge clk);
        checkOutput({tag, "_err_count"}, err_count, cnt);
        checkOutput({tag, "_abs_err_acc"}, abs_err_acc, acc);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [3:0] pat;
        int lat;
        pat = 4'b1001;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_k = '0;
        out_ready = 1'b1;
        stats_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_sum", out_sum, 0);
        checkOutput("rst_out_exact", out_exact, 0);
        checkOutput("rst_out_err", out_err, 0);
        checkOutput("rst_err_count", err_count, 0);
        checkOutput("rst_abs_err_acc", abs_err_acc, 0);

        syncDrive();
        applyStimulus(8'h07, 8'h01, 4'd3);
        expectResult("t1", 9'h007, 9'h008, 1'b1);
        expectStats("t1", 1, 1);

        syncDrive();
        applyStimulus(8'hFF, 8'h01, 4'd3);
        expectResult("t2", 9'h0FF, 9'h100, 1'b1);
        expectStats("t2", 2, 2);

        syncDrive();
        applyStimulus(8'hFF, 8'h01, 4'd0);
        expectResult("t3", 9'h100, 9'h100, 1'b0);
        expectStats("t3", 2, 2);

        syncDrive();
        applyStimulus(8'hFF, 8'hFF, 4'd8);
        expectResult("t4", 9'h0FF, 9'h1FE, 1'b1);
        expectStats("t4", 3, 257);

        syncDrive();
        applyStimulus(8'hFF, 8'hFF, 4'd15);
        expectResult("t5", 9'h0FF, 9'h1FE, 1'b1);
        expectStats("t5", 4, 512);

        syncDrive();
        applyStimulus(8'h0F, 8'hF0, 4'd8);
        expectResult("t6", 9'h0FF, 9'h0FF, 1'b0);
        expectStats("t6", 4, 512);

        syncDrive();
        fork
            begin
                for (int i = 0; i < 10; i++)
                    applyStimulus(8'((i * 29 + 3) & 8'hFF), 8'((i * 71) & 8'hFF), 4'(i % 10));
            end
            begin
                for (int i = 0; i < 16; i++) begin
                    out_ready = pat[i % 4];
                    syncDrive();
                end
                out_ready = 1'b1;
            end
        join
        waitDrain();

        syncDrive();
        for (int i = 0; i < 16; i++) applyStimulus(8'h07, 8'h01, 4'd3);
        waitDrain();
        checkOutput("cnt_saturated", err_count, 4'hF);

        syncDrive();
        for (int i = 0; i < 17; i++) applyStimulus(8'hFF, 8'hFF, 4'd8);
        waitDrain();
        checkOutput("acc_saturated", abs_err_acc, 12'hFFF);

        syncDrive();
        stats_clear = 1'b1;
        syncDrive();
        stats_clear = 1'b0;
        expectStats("clear_idle", 0, 0);

        syncDrive();
        applyStimulus(8'h07, 8'h01, 4'd3);
        syncDrive();
        stats_clear = 1'b1;
        syncDrive();
        stats_clear = 1'b0;
        expectStats("clear_with_hs", 1, 1);

        syncDrive();
        out_ready = 1'b0;
        applyStimulus(8'h11, 8'h22, 4'd2);
        applyStimulus(8'h33, 8'h44, 4'd1);
        rst = 1'b1;
        repeat (2) syncDrive();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("no_out_after_reset", out_valid, 0);
        end
        checkOutput("reset_err_count", err_count, 0);
        checkOutput("reset_abs_err_acc", abs_err_acc, 0);

        syncDrive();
        applyStimulus(8'hFF, 8'h01, 4'd0);
        expectResult("post_reset", 9'h100, 9'h100, 1'b0);
        waitDrain();
        checkOutput("queue_empty", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
